// File: rtl/demux_2ch_deserializer_if.sv
// Bus between the 1-to-2 demux front end and the per-channel word consumers.
// master drives the serial bits and readies; slave is the deserializer.
interface demux_2ch_deserializer_if #(
  parameter int W = 8
) ();
  logic         in_valid;
  logic         sel;
  logic         out1;
  logic         out2;
  logic         sync_clr;
  logic [W-1:0] ch0_data;
  logic         ch0_valid;
  logic         ch0_ready;
  logic [W-1:0] ch1_data;
  logic         ch1_valid;
  logic         ch1_ready;
  logic         ch0_ovf;
  logic         ch1_ovf;

  modport master (
    output in_valid, sel, out1, out2, sync_clr, ch0_ready, ch1_ready,
    input  ch0_data, ch0_valid, ch1_data, ch1_valid, ch0_ovf, ch1_ovf
  );

  modport slave (
    input  in_valid, sel, out1, out2, sync_clr, ch0_ready, ch1_ready,
    output ch0_data, ch0_valid, ch1_data, ch1_valid, ch0_ovf, ch1_ovf
  );
endinterface

// File: rtl/demux_2ch_deserializer.sv
// Two-channel MSB-first deserializer behind a 1-to-2 bit demux; word valid 1 cycle after its last bit.
// Backpressure: one holding word per channel, a word completing into a full, non-draining holder is dropped and flagged in a sticky ovf.
module demux_2ch_deserializer #(
  parameter int W    = 8,
  parameter int CNTW = $clog2(W)
) (
  input logic                     clk,
  input logic                     rst_n,
  demux_2ch_deserializer_if.slave bus
);
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(W - 1);

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic            bit_in;
    logic            rdy;
    logic            cap;
    logic            done;
    logic            xfer;
    logic [W-1:0]    word;
    logic [W-2:0]    shift_q;
    logic [CNTW-1:0] cnt_q;
    logic [W-1:0]    data_q;
    logic            valid_q;
    logic            ovf_q;

    assign bit_in = (c == 0) ? bus.out1 : bus.out2;
    assign rdy    = (c == 0) ? bus.ch0_ready : bus.ch1_ready;

    // sync_clr outranks capture, so a bit arriving with it is discarded.
    assign cap  = bus.in_valid & (bus.sel == 1'(c)) & ~bus.sync_clr;
    assign done = cap & (cnt_q == LAST_BIT);
    assign xfer = valid_q & rdy;
    assign word = {shift_q, bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shift_q <= '0;
        cnt_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        if (bus.sync_clr) begin
          shift_q <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end else if (cap) begin
          shift_q <= word[W-2:0];
          cnt_q   <= done ? '0 : cnt_q + CNTW'(1);
        end

        // A drain on the completion edge frees the holder in time for the new word.
        if (done) begin
          if (!valid_q || xfer) begin
            data_q  <= word;
            valid_q <= 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end else if (xfer) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.ch0_data  = g_ch[0].data_q;
  assign bus.ch0_valid = g_ch[0].valid_q;
  assign bus.ch0_ovf   = g_ch[0].ovf_q;
  assign bus.ch1_data  = g_ch[1].data_q;
  assign bus.ch1_valid = g_ch[1].valid_q;
  assign bus.ch1_ovf   = g_ch[1].ovf_q;
endmodule

// File: tb/tb_demux_2ch_deserializer.sv
// Directed plus random bench for demux_2ch_deserializer against a bit-queue reference model.
module tb_demux_2ch_deserializer;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  // reference model: captured bits per channel, holding word, valid, overflow
  logic         q0[$];
  logic         q1[$];
  logic [W-1:0] m_data[2];
  logic         m_valid[2];
  logic         m_ovf[2];

  demux_2ch_deserializer_if #(.W(W)) bus ();

  demux_2ch_deserializer #(.W(W), .CNTW($clog2(W))) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int c = 0; c < 2; c++) begin
      m_data[c]  = '0;
      m_valid[c] = 1'b0;
      m_ovf[c]   = 1'b0;
    end
  endtask

  // Applied once per rising edge, using the inputs that were held across it.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      logic         rdy;
      logic         xfer;
      logic         done;
      logic         b;
      logic [W-1:0] w;
      rdy  = (c == 0) ? bus.ch0_ready : bus.ch1_ready;
      xfer = m_valid[c] && rdy;
      done = 1'b0;
      w    = '0;
      if (bus.sync_clr) begin
        if (c == 0) q0.delete(); else q1.delete();
        m_ovf[c] = 1'b0;
      end else if (bus.in_valid && (int'(bus.sel) == c)) begin
        b = (c == 0) ? bus.out1 : bus.out2;
        if (c == 0) begin
          q0.push_back(b);
          if (q0.size() == W) begin
            for (int i = 0; i < W; i++) w[W-1-i] = q0[i];
            q0.delete();
            done = 1'b1;
          end
        end else begin
          q1.push_back(b);
          if (q1.size() == W) begin
            for (int i = 0; i < W; i++) w[W-1-i] = q1[i];
            q1.delete();
            done = 1'b1;
          end
        end
        if (done) begin
          if (!m_valid[c] || xfer) begin
            m_data[c]  = w;
            m_valid[c] = 1'b1;
          end else begin
            m_ovf[c] = 1'b1;
          end
        end
      end
      if (!done && xfer) m_valid[c] = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("ch0_data",  bus.ch0_data,        m_data[0]);
    chk("ch0_valid", W'(bus.ch0_valid),   W'(m_valid[0]));
    chk("ch0_ovf",   W'(bus.ch0_ovf),     W'(m_ovf[0]));
    chk("ch1_data",  bus.ch1_data,        m_data[1]);
    chk("ch1_valid", W'(bus.ch1_valid),   W'(m_valid[1]));
    chk("ch1_ovf",   W'(bus.ch1_ovf),     W'(m_ovf[1]));
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic cycle(input logic iv, input logic s, input logic o1, input logic o2,
                       input logic clr, input logic r0, input logic r1);
    bus.in_valid  = iv;
    bus.sel       = s;
    bus.out1      = o1;
    bus.out2      = o2;
    bus.sync_clr  = clr;
    bus.ch0_ready = r0;
    bus.ch1_ready = r1;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle(input logic r0, input logic r1);
    cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, r0, r1);
  endtask

  task automatic send_word(input int ch, input logic [W-1:0] w, input int gaps,
                           input logic rb0, input logic rb1, input logic rl0, input logic rl1);
    for (int i = W - 1; i >= 0; i--) begin
      logic b;
      logic last;
      b    = w[i];
      last = (i == 0);
      if (gaps != 0)
        repeat ($urandom_range(2)) idle(rb0, rb1);
      cycle(1'b1, 1'(ch), (ch == 0) ? b : 1'($urandom), (ch == 1) ? b : 1'($urandom),
            1'b0, last ? rl0 : rb0, last ? rl1 : rb1);
    end
  endtask

  task automatic send_bits(input int ch, input int n, input logic r0, input logic r1);
    repeat (n) cycle(1'b1, 1'(ch), 1'($urandom), 1'($urandom), 1'b0, r0, r1);
  endtask

  initial begin
    logic [W-1:0] gw0;
    logic [W-1:0] gw1;
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sel       = 1'b0;
    bus.out1      = 1'b0;
    bus.out2      = 1'b0;
    bus.sync_clr  = 1'b0;
    bus.ch0_ready = 1'b0;
    bus.ch1_ready = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch0_data",  bus.ch0_data, 8'h00);
    chk("rst_ch0_valid", W'(bus.ch0_valid), 8'h00);
    chk("rst_ch1_valid", W'(bus.ch1_valid), 8'h00);
    chk("rst_ovf",       W'({bus.ch1_ovf, bus.ch0_ovf}), 8'h00);
    rst_n = 1'b1;

    // 1: single word on ch0
    send_word(0, 8'hA5, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("s1_ch0_valid", W'(bus.ch0_valid), 8'h01);
    chk("s1_ch0_data",  bus.ch0_data, 8'hA5);
    chk("s1_ch1_valid", W'(bus.ch1_valid), 8'h00);
    idle(1'b1, 1'b1);
    chk("s1_ch0_drained", W'(bus.ch0_valid), 8'h00);

    // 2: interleaved channels, both held
    gw0 = 8'h3C;
    gw1 = 8'hC3;
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b1, 1'b0, gw0[i], 1'($urandom), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'($urandom), gw1[i], 1'b0, 1'b0, 1'b0);
      if (i == 1) chk("s2_ch0_early", W'(bus.ch0_valid), 8'h00);
    end
    chk("s2_ch0_data", bus.ch0_data, 8'h3C);
    chk("s2_ch1_data", bus.ch1_data, 8'hC3);
    chk("s2_both_valid", W'({bus.ch1_valid, bus.ch0_valid}), 8'h03);
    idle(1'b1, 1'b1);

    // 3: backpressure overflow on ch1
    send_word(1, 8'h11, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(1, 8'h22, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s3_ch1_data", bus.ch1_data, 8'h11);
    chk("s3_ch1_ovf",  W'(bus.ch1_ovf), 8'h01);
    idle(1'b1, 1'b1);
    chk("s3_ch1_drained", W'(bus.ch1_valid), 8'h00);

    // 4: drain and completion on the same edge
    send_word(0, 8'h11, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_word(0, 8'h77, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("s4_ch0_valid", W'(bus.ch0_valid), 8'h01);
    chk("s4_ch0_data",  bus.ch0_data, 8'h77);
    chk("s4_ch0_ovf",   W'(bus.ch0_ovf), 8'h00);
    idle(1'b1, 1'b1);

    // 5a: async reset mid-word
    send_bits(0, 4, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s5_rst_data",  bus.ch0_data | bus.ch1_data, 8'h00);
    chk("s5_rst_flags", W'({bus.ch1_ovf, bus.ch0_ovf, bus.ch1_valid, bus.ch0_valid}), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(0, 8'hF0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_after_rst", bus.ch0_data, 8'hF0);

    // 5b: sync_clr mid-word with a held word and an overflow on ch1
    send_word(1, 8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(1, 8'h99, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_ch1_ovf_set", W'(bus.ch1_ovf), 8'h01);
    idle(1'b1, 1'b0);
    send_bits(0, 4, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("s5_clr_ch1_data",  bus.ch1_data, 8'h5A);
    chk("s5_clr_ch1_valid", W'(bus.ch1_valid), 8'h01);
    chk("s5_clr_ch1_ovf",   W'(bus.ch1_ovf), 8'h00);
    send_word(0, 8'hF0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_after_clr", bus.ch0_data, 8'hF0);
    idle(1'b1, 1'b1);

    // 6: in_valid=0 gaps between captured bits
    gw0 = W'($urandom);
    gw1 = W'($urandom);
    send_word(0, gw0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(1, gw1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_ch0_gap_word", bus.ch0_data, gw0);
    chk("s6_ch1_gap_word", bus.ch1_data, gw1);
    idle(1'b1, 1'b1);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      cycle(1'($urandom_range(99) < 60), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(63) == 0), 1'($urandom_range(99) < 40), 1'($urandom_range(99) < 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
